cbm2_ram_seq: RTL and testbench

Slot-based SDRAM access sequencer inside `cbm2_main`. It is the initiator side of the byte-wide `ramAddr/ramCE/ramWE/ramOut/ramData/refresh` interface served by the `sdram` controller. It divides each 1 MHz system cycle into fixed clk_sys slots and issues exactly one video read, one CPU access and one refresh per cycle. It also maps CBM-II segment/bank numbers onto SDRAM addresses according to the configured RAM size.

---
 rtl/cbm2_ram_seq.sv | 177 +++++++++++++++++
 tb/tb_cbm2_ram_seq.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cbm2_ram_seq.sv
// cbm2_ram_seq
// Slot-based SDRAM access sequencer for the CBM-II core. Each system cycle of
// CYCLE_LEN clk_sys ticks is split into fixed slots. The video read is issued at
// VID_SLOT, the CPU access at CPU_SLOT and the refresh pulse at REF_SLOT. CPU
// segment/bank numbers are range-checked against the RAM size that is latched at
// the start of the cycle.
//
// Ports
//   clk_sys, reset_n      : clock (rising edge), asynchronous active-low reset
//   ramSize[1:0]          : 00=128K 01=256K 10=1M 11=16M, latched at phase 0
//   cpu_req/we/bank/addr  : CPU access request, sampled at CPU_SLOT
//   cpu_dout[7:0]         : CPU write data
//   cpu_din[7:0]          : CPU read data, held until the next read ack
//   cpu_ack               : one-cycle pulse at CPU_SLOT+RD_LAT
//   vid_req, vid_addr     : video fetch request (bank 0), sampled at VID_SLOT
//   vid_data, vid_valid   : fetched byte and its one-cycle update strobe
//   phi2, cycle_start     : system cycle phase indications
//   ramAddr/CE/WE/Out     : SDRAM request side
//   ramData[7:0]          : SDRAM read data
//   refresh               : one-cycle refresh request
module cbm2_ram_seq #(
  parameter int CYCLE_LEN = 32,
  parameter int VID_SLOT  = 2,
  parameter int CPU_SLOT  = 16,
  parameter int REF_SLOT  = 26,
  parameter int RD_LAT    = 6
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [1:0]  ramSize,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [7:0]  cpu_bank,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_din,
  output logic        cpu_ack,
  input  logic        vid_req,
  input  logic [15:0] vid_addr,
  output logic [7:0]  vid_data,
  output logic        vid_valid,
  output logic        phi2,
  output logic        cycle_start,
  output logic [24:0] ramAddr,
  output logic        ramCE,
  output logic        ramWE,
  output logic [7:0]  ramOut,
  input  logic [7:0]  ramData,
  output logic        refresh
);

  if ((VID_SLOT + RD_LAT >= CPU_SLOT) || (CPU_SLOT + RD_LAT >= REF_SLOT) ||
      (REF_SLOT >= CYCLE_LEN) || (CYCLE_LEN > 64)) begin : g_param_check
    $fatal(1, "cbm2_ram_seq: slot parameters overlap or exceed the cycle");
  end

  localparam logic [5:0] PH_LAST  = 6'(CYCLE_LEN - 1);
  localparam logic [5:0] PH_HALF  = 6'(CYCLE_LEN / 2);
  localparam logic [5:0] VID_PH   = 6'(VID_SLOT);
  localparam logic [5:0] VID_DONE = 6'(VID_SLOT + RD_LAT);
  localparam logic [5:0] CPU_PH   = 6'(CPU_SLOT);
  localparam logic [5:0] CPU_DONE = 6'(CPU_SLOT + RD_LAT);
  localparam logic [5:0] REF_PH   = 6'(REF_SLOT);

  logic [5:0] ph;
  logic [5:0] ph_nxt;
  logic       run;
  logic [1:0] size_q;
  logic [7:0] bank_mask;
  logic       bank_ok;
  logic       vid_pend;
  logic       cpu_pend;
  logic       cpu_rd;
  logic       cpu_oor;

  // Outputs are registered from the phase being entered so that every strobe
  // is high exactly while ph equals its slot. The run flag holds ph at 0 for
  // the first tick after reset so cycle_start stays low during reset and rises
  // in the first cycle after release.
  always_comb begin
    ph_nxt = '0;
    if (run && (ph != PH_LAST)) begin
      ph_nxt = ph + 6'd1;
    end
  end

  always_comb begin
    bank_mask = 8'h01;
    case (size_q)
      2'b00:   bank_mask = 8'h01;
      2'b01:   bank_mask = 8'h03;
      2'b10:   bank_mask = 8'h0F;
      default: bank_mask = 8'hFF;
    endcase
  end

  assign bank_ok = ((cpu_bank & ~bank_mask) == '0);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ph          <= '0;
      run         <= 1'b0;
      size_q      <= 2'b00;
      cycle_start <= 1'b0;
      phi2        <= 1'b0;
      refresh     <= 1'b0;
      ramCE       <= 1'b0;
      ramWE       <= 1'b0;
      ramAddr     <= '0;
      ramOut      <= '0;
      cpu_ack     <= 1'b0;
      cpu_din     <= '1;
      vid_valid   <= 1'b0;
      vid_data    <= '0;
      vid_pend    <= 1'b0;
      cpu_pend    <= 1'b0;
      cpu_rd      <= 1'b0;
      cpu_oor     <= 1'b0;
    end else begin
      run         <= 1'b1;
      ph          <= ph_nxt;
      cycle_start <= (ph_nxt == '0);
      phi2        <= (ph_nxt >= PH_HALF);
      refresh     <= (ph_nxt == REF_PH);
      ramCE       <= 1'b0;
      cpu_ack     <= 1'b0;
      vid_valid   <= 1'b0;

      if (ph_nxt == '0) begin
        size_q <= ramSize;
      end

      if (ph_nxt == VID_PH) begin
        vid_pend <= vid_req;
        if (vid_req) begin
          ramCE   <= 1'b1;
          ramWE   <= 1'b0;
          ramAddr <= {9'b0, vid_addr};
        end
      end

      if (ph_nxt == VID_DONE) begin
        vid_pend <= 1'b0;
        if (vid_pend) begin
          vid_data  <= ramData;
          vid_valid <= 1'b1;
        end
      end

      if (ph_nxt == CPU_PH) begin
        cpu_pend <= cpu_req;
        cpu_rd   <= ~cpu_we;
        cpu_oor  <= ~bank_ok;
        if (cpu_req && bank_ok) begin
          ramCE   <= 1'b1;
          ramWE   <= cpu_we;
          ramAddr <= {1'b0, cpu_bank, cpu_addr};
          if (cpu_we) begin
            ramOut <= cpu_dout;
          end
        end
      end

      // Out-of-range reads return open bus; writes leave cpu_din untouched.
      if (ph_nxt == CPU_DONE) begin
        cpu_pend <= 1'b0;
        if (cpu_pend) begin
          cpu_ack <= 1'b1;
          if (cpu_rd) begin
            cpu_din <= cpu_oor ? 8'hFF : ramData;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_cbm2_ram_seq.sv
// Testbench for cbm2_ram_seq: directed test-plan cycles followed by random
// system cycles. Expected SDRAM strobes, CPU acks and video fetches are queued
// per cycle from a memory-level reference model and popped by a monitor.
module tb_cbm2_ram_seq;

  localparam int CL = 32;
  localparam int VS = 2;
  localparam int CS = 16;
  localparam int RS = 26;
  localparam int RL = 6;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  ramSize = 2'b00;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [7:0]  cpu_bank = '0;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_dout = '0;
  logic [7:0]  cpu_din;
  logic        cpu_ack;
  logic        vid_req = 1'b0;
  logic [15:0] vid_addr = '0;
  logic [7:0]  vid_data;
  logic        vid_valid;
  logic        phi2;
  logic        cycle_start;
  logic [24:0] ramAddr;
  logic        ramCE;
  logic        ramWE;
  logic [7:0]  ramOut;
  logic [7:0]  ramData = '0;
  logic        refresh;

  always #5 clk_sys = ~clk_sys;

  cbm2_ram_seq #(
    .CYCLE_LEN(CL),
    .VID_SLOT (VS),
    .CPU_SLOT (CS),
    .REF_SLOT (RS),
    .RD_LAT   (RL)
  ) dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .ramSize    (ramSize),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_bank   (cpu_bank),
    .cpu_addr   (cpu_addr),
    .cpu_dout   (cpu_dout),
    .cpu_din    (cpu_din),
    .cpu_ack    (cpu_ack),
    .vid_req    (vid_req),
    .vid_addr   (vid_addr),
    .vid_data   (vid_data),
    .vid_valid  (vid_valid),
    .phi2       (phi2),
    .cycle_start(cycle_start),
    .ramAddr    (ramAddr),
    .ramCE      (ramCE),
    .ramWE      (ramWE),
    .ramOut     (ramOut),
    .ramData    (ramData),
    .refresh    (refresh)
  );

  typedef struct {
    logic [1:0]  size;
    logic        vreq;
    logic [15:0] vaddr;
    logic        creq;
    logic        cwe;
    logic [7:0]  cbank;
    logic [15:0] caddr;
    logic [7:0]  cdout;
  } rec_t;

  typedef struct {
    int          ph;
    logic        we;
    logic [24:0] addr;
    logic [7:0]  wd;
  } ce_t;

  typedef struct {
    int         ph;
    logic [7:0] d;
  } rd_t;

  ce_t        ce_q[$];
  rd_t        ack_q[$];
  rd_t        vid_q[$];
  rec_t       recs[$];
  logic [7:0] ref_mem[int];
  logic [7:0] sd_mem[int];

  int         checks = 0;
  int         failures = 0;
  int         cnt = 0;
  int         cur_ph = 0;
  logic [7:0] din_exp = 8'hFF;
  logic [7:0] last_din = 8'hFF;

  function automatic logic [7:0] dflt(input logic [24:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] ref_rd(input logic [24:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return dflt(a);
  endfunction

  function automatic logic [7:0] sd_rd(input logic [24:0] a);
    if (sd_mem.exists(int'(a))) return sd_mem[int'(a)];
    return dflt(a);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s phase=%0d actual=%0h required=%0h", name, cur_ph, act, req);
    end
  endtask

  // SDRAM model: read data is valid only during the tick before the
  // RD_LAT-th edge after the strobe, and inverted otherwise.
  int         rd_cnt = 0;
  logic [7:0] rd_val = '0;
  always @(posedge clk_sys) begin
    if (ramCE && ramWE) sd_mem[int'(ramAddr)] = ramOut;
    if (ramCE && !ramWE) begin
      rd_val = sd_rd(ramAddr);
      rd_cnt = 1;
    end else if (rd_cnt > 0) begin
      rd_cnt++;
    end
    ramData <= (rd_cnt == RL - 1) ? rd_val : ~rd_val;
  end

  // Edges since reset release; the first one enters phase 0.
  always @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) cnt = 0;
    else cnt = cnt + 1;
  end

  always @(negedge clk_sys) begin
    ce_t e;
    rd_t r;
    logic exp_s;
    if (!reset_n) begin
      cur_ph = 0;
      check("rst_ramCE", ramCE, 0);
      check("rst_cycle_start", cycle_start, 0);
      check("rst_cpu_din", cpu_din, 8'hFF);
      check("rst_strobes", {ramWE, refresh, cpu_ack, vid_valid, phi2}, 0);
      check("rst_ramAddr", ramAddr, 0);
      check("rst_ramOut_vid", {ramOut, vid_data}, 0);
      din_exp = 8'hFF;
    end else if (cnt > 0) begin
      cur_ph = (cnt - 1) % CL;
      check("cycle_start", cycle_start, cur_ph == 0);
      check("phi2", phi2, cur_ph >= CL / 2);
      check("refresh", refresh, cur_ph == RS);

      exp_s = (ce_q.size() > 0) && (ce_q[0].ph == cur_ph);
      check("ramCE", ramCE, exp_s);
      if (ramCE && exp_s) begin
        e = ce_q.pop_front();
        check("ramWE", ramWE, e.we);
        check("ramAddr", ramAddr, e.addr);
        if (e.we) check("ramOut", ramOut, e.wd);
      end

      exp_s = (vid_q.size() > 0) && (vid_q[0].ph == cur_ph);
      check("vid_valid", vid_valid, exp_s);
      if (vid_valid && exp_s) begin
        r = vid_q.pop_front();
        check("vid_data", vid_data, r.d);
      end

      exp_s = (ack_q.size() > 0) && (ack_q[0].ph == cur_ph);
      check("cpu_ack", cpu_ack, exp_s);
      if (cpu_ack && exp_s) begin
        r = ack_q.pop_front();
        din_exp = r.d;
      end
      check("cpu_din", cpu_din, din_exp);
    end
  end

  task automatic push_cycle(input rec_t r);
    logic [7:0]  mask;
    logic [24:0] a;
    ce_t         c;
    rd_t         d;
    case (r.size)
      2'd0:    mask = 8'h01;
      2'd1:    mask = 8'h03;
      2'd2:    mask = 8'h0F;
      default: mask = 8'hFF;
    endcase
    if (r.vreq) begin
      a = {9'b0, r.vaddr};
      c.ph = VS; c.we = 1'b0; c.addr = a; c.wd = '0;
      ce_q.push_back(c);
      d.ph = VS + RL; d.d = ref_rd(a);
      vid_q.push_back(d);
    end
    if (r.creq) begin
      a = {1'b0, r.cbank, r.caddr};
      if ((r.cbank & ~mask) == 8'h00) begin
        c.ph = CS; c.we = r.cwe; c.addr = a; c.wd = r.cdout;
        ce_q.push_back(c);
        if (r.cwe) ref_mem[int'(a)] = r.cdout;
        else last_din = ref_rd(a);
      end else if (!r.cwe) begin
        last_din = 8'hFF;
      end
      d.ph = CS + RL; d.d = last_din;
      ack_q.push_back(d);
    end
  endtask

  task automatic drive(input rec_t r);
    vid_req  = r.vreq;
    vid_addr = r.vaddr;
    cpu_req  = r.creq;
    cpu_we   = r.cwe;
    cpu_bank = r.cbank;
    cpu_addr = r.caddr;
    cpu_dout = r.cdout;
  endtask

  function automatic rec_t mk(input logic [1:0] size, input logic vreq, input logic [15:0] vaddr,
                              input logic creq, input logic cwe, input logic [7:0] cbank,
                              input logic [15:0] caddr, input logic [7:0] cdout);
    rec_t r;
    r.size = size; r.vreq = vreq; r.vaddr = vaddr; r.creq = creq;
    r.cwe = cwe; r.cbank = cbank; r.caddr = caddr; r.cdout = cdout;
    return r;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog phase=%0d actual=timeout required=finish", cur_ph);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rec_t r;
    ref_mem[int'(25'h0031234)] = 8'hA5;
    sd_mem[int'(25'h0031234)]  = 8'hA5;

    recs.push_back(mk(2'b01, 1'b0, 16'h0000, 1'b1, 1'b0, 8'h03, 16'h1234, 8'h00));
    recs.push_back(mk(2'b00, 1'b0, 16'h0000, 1'b1, 1'b1, 8'h02, 16'h0010, 8'h5A));
    recs.push_back(mk(2'b00, 1'b0, 16'h0000, 1'b1, 1'b0, 8'h02, 16'h0010, 8'h00));
    recs.push_back(mk(2'b11, 1'b0, 16'h0000, 1'b1, 1'b1, 8'hFE, 16'hFFFF, 8'h3C));
    recs.push_back(mk(2'b11, 1'b1, 16'h0400, 1'b1, 1'b0, 8'hFE, 16'hFFFF, 8'h00));
    recs.push_back(mk(2'b10, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 8'h00));
    for (int i = 0; i < 40; i++) begin
      r.size  = 2'($urandom_range(0, 3));
      r.vreq  = 1'($urandom_range(0, 1));
      r.vaddr = ($urandom_range(0, 1) != 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
      r.creq  = ($urandom_range(0, 3) != 0);
      r.cwe   = 1'($urandom_range(0, 1));
      r.cbank = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
      r.caddr = ($urandom_range(0, 1) != 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
      r.cdout = 8'($urandom);
      recs.push_back(r);
    end

    ramSize = recs[0].size;
    reset_n = 1'b0;
    repeat (3) @(negedge clk_sys);
    #2 reset_n = 1'b1;

    for (int n = 0; n < recs.size(); n++) begin
      for (int p = 0; p < CL; p++) begin
        @(negedge clk_sys);
        if (p == 0) begin
          drive(recs[n]);
          push_cycle(recs[n]);
        end
        // Scribble ramSize mid-cycle; only the value present at phase 0 counts.
        if (p == 5) ramSize = 2'($urandom);
        if (p == 20) ramSize = (n + 1 < recs.size()) ? recs[n + 1].size : 2'b11;
      end
    end

    // Reset in the middle of an in-range CPU read, after its strobe.
    r = mk(2'b11, 1'b0, 16'h0000, 1'b1, 1'b0, 8'h05, 16'h0777, 8'h00);
    for (int p = 0; p <= CS + 2; p++) begin
      @(negedge clk_sys);
      if (p == 0) begin
        drive(r);
        push_cycle(r);
      end
    end
    #2 reset_n = 1'b0;
    ack_q.delete();
    last_din = 8'hFF;
    r = mk(2'b00, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 8'h00);
    drive(r);
    repeat (3) @(negedge clk_sys);
    #2 reset_n = 1'b1;
    repeat (2 * CL) @(negedge clk_sys);

    check("ce_q_left", ce_q.size(), 0);
    check("ack_q_left", ack_q.size(), 0);
    check("vid_q_left", vid_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
